// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
package fetch_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Width able to hold every occupancy value 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO with a synchronous flush; holds both fetched instructions
// and the PCs of in-flight requests.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       valid,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; count and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end with branch/exception redirect.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br,
  input  logic [31:0] pc_branch,
  input  logic        except,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  localparam int CW = cnt_width(DEPTH);
  localparam int OW = cnt_width(MAX_OUTST);

  logic          redirect, issue, resp_live, pop;
  logic [31:0]   fetch_pc, tag_pc;
  logic [CW-1:0] q_count;
  logic [OW-1:0] tag_count, outst, drop;
  logic          q_valid, tag_valid;
  fetch_entry_t  q_head, q_in;

  assign redirect  = br | except;
  // Reserve a queue slot for every in-flight request so responses never overflow.
  assign issue     = !rst && !redirect && (int'(outst) < MAX_OUTST)
                     && (int'(q_count) + int'(outst) < DEPTH);
  assign resp_live = imem_rvalid && (drop == '0) && !redirect;
  assign pop       = q_valid && id_ready;
  assign q_in      = '{pc: tag_pc, inst: imem_rdata};

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign if_valid  = q_valid;
  assign if_pc     = q_valid ? q_head.pc   : '0;
  assign if_inst   = q_valid ? q_head.inst : '0;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (resp_live),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  fetch_fifo #(.DEPTH(MAX_OUTST), .entry_t(logic [31:0])) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (resp_live),
    .head      (tag_pc),
    .valid     (tag_valid),
    .count     (tag_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst + OW'(issue) - OW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= except ? EXC_VECTOR : pc_branch;
        // Everything still in flight is stale, except a response consumed now.
        drop     <= outst - OW'(imem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid && (drop != '0)) drop <= drop - OW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop)      fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

  // Protocol and bookkeeping invariants.
  assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outst != '0));
  assert property (@(posedge clk) disable iff (rst)
                   int'(outst) == int'(drop) + int'(tag_count));
  assert property (@(posedge clk) disable iff (rst)
                   (imem_rvalid && (drop == '0)) |-> tag_valid);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model plus literal spot checks.
module tb_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC       = 32'h8000_0180;

  logic        clk = 1'b0, rst = 1'b1;
  logic        br = 1'b0, except = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b0;
  logic [31:0] pc_branch = '0, imem_rdata = '0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_inst, fetch_cnt, flush_cnt;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .br          (br),
    .pc_branch   (pc_branch),
    .except      (except),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .id_ready    (id_ready),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ent_t  mq[$];        // model instruction queue
  req_t  inflight[$];  // model in-flight requests
  mreq_t mem_q[$];     // memory environment
  logic [31:0] m_pc;
  int m_fetch, m_flush, cyc, mem_lat;
  int n_vec = 0, n_err = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1; br = 1'b0; except = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    mem_q.delete(); mq.delete(); inflight.delete();
    m_pc = RESET_PC; m_fetch = 0; m_flush = 0; mem_lat = lat;
    repeat (2) @(negedge clk);
    check("rst_imem_req",  {31'b0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_if_valid",  {31'b0, if_valid}, 32'd0);
    check("rst_if_pc",     if_pc, 32'd0);
    check("rst_if_inst",   if_inst, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    rst = 1'b0;
    cyc = 0;
  endtask

  // One clock cycle: called at a negedge, drives inputs, compares, advances model.
  task automatic cycle(input logic b, input logic e, input logic [31:0] tgt, input logic rdy);
    logic redir, exp_req, exp_valid;
    logic [31:0] exp_pc, exp_inst;
    req_t r;
    br = b; except = e; pc_branch = tgt; id_ready = rdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].addr + 32'h100;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    redir     = b || e;
    exp_valid = (mq.size() > 0);
    exp_pc    = exp_valid ? mq[0].pc   : 32'd0;
    exp_inst  = exp_valid ? mq[0].inst : 32'd0;
    exp_req   = !redir && (inflight.size() < MAX_OUTST)
                && (mq.size() + inflight.size() < DEPTH);
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_pc = if_pc; s_inst = if_inst;
    check("imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
    check("imem_addr", imem_addr, m_pc);
    check("if_valid",  {31'b0, if_valid}, {31'b0, exp_valid});
    check("if_pc",     if_pc, exp_pc);
    check("if_inst",   if_inst, exp_inst);
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("flush_cnt", flush_cnt, m_flush);
`else
    check("fetch_cnt", fetch_cnt, 32'd0);
    check("flush_cnt", flush_cnt, 32'd0);
`endif
    if (imem_req) mem_q.push_back('{imem_addr, cyc + mem_lat});
    if (exp_valid && rdy) begin
      void'(mq.pop_front());
      m_fetch++;
    end
    if (imem_rvalid && inflight.size() > 0) begin
      r = inflight.pop_front();
      if (!r.stale && !redir) mq.push_back('{r.pc, r.pc + 32'h100});
    end
    if (redir) begin
      mq.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc = e ? EXC : tgt;
      m_flush++;
    end else if (exp_req) begin
      inflight.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_valid(input int budget, output logic [31:0] pc, output bit ok);
    ok = 1'b0; pc = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      if (s_valid) begin ok = 1'b1; pc = s_pc; end
    end
  endtask

  initial begin
    logic [31:0] fpc;
    bit ok, found;

    // Streaming with 1-cycle memory.
    do_reset(1);
    cycle(0, 0, 0, 1);
    check("lit_first_req",  {31'b0, s_req}, 32'd1);
    check("lit_first_addr", s_addr, 32'h0);
    cycle(0, 0, 0, 1);
    check("lit_second_addr", s_addr, 32'h4);
    check("lit_no_bypass",   {31'b0, s_valid}, 32'd0);
    cycle(0, 0, 0, 1);
    check("lit_c2_valid", {31'b0, s_valid}, 32'd1);
    check("lit_c2_pc",    s_pc, 32'h0);
    check("lit_c2_inst",  s_inst, 32'h100);
    cycle(0, 0, 0, 1);
    check("lit_c3_pc", s_pc, 32'h4);
    repeat (6) cycle(0, 0, 0, 1);

    // Exception wins over branch, then address wrap.
    cycle(1, 1, 32'h400, 1);
    cycle(0, 0, 0, 1);
    check("lit_exc_addr",   s_addr, EXC);
    check("lit_exc_req",    {31'b0, s_req}, 32'd1);
    check("lit_exc_empty",  {31'b0, s_valid}, 32'd0);
    run_until_valid(5, fpc, ok);
    check("lit_exc_found", {31'b0, ok}, 32'd1);
    check("lit_exc_pc",    fpc, EXC);
    cycle(1, 0, 32'hFFFF_FFF8, 1);
    cycle(0, 0, 0, 1);
    check("lit_wrap_a", s_addr, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 1);
    check("lit_wrap_b", s_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    check("lit_wrap_c",   s_addr, 32'h0);
    check("lit_wrap_req", {31'b0, s_req}, 32'd1);
    repeat (5) cycle(0, 0, 0, 1);

    // Backpressure: queue fills to DEPTH, then drains in order.
    do_reset(1);
    repeat (8) cycle(0, 0, 0, 0);
    check("lit_full_req",   {31'b0, s_req}, 32'd0);
    check("lit_full_valid", {31'b0, s_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      check("lit_drain_pc", s_pc, 32'(4 * i));
    end
    repeat (6) cycle(0, 0, 0, 1);

    // Branch with two requests in flight on a 3-cycle memory.
    do_reset(3);
    repeat (2) cycle(0, 0, 0, 1);
    cycle(1, 0, 32'h400, 1);
    cycle(0, 0, 0, 1);
    check("lit_br_addr",  s_addr, 32'h400);
    check("lit_br_empty", {31'b0, s_valid}, 32'd0);
    run_until_valid(12, fpc, ok);
    check("lit_br_found", {31'b0, ok}, 32'd1);
    check("lit_br_pc",    fpc, 32'h400);
    repeat (4) cycle(0, 0, 0, 1);

    // Redirect on a response cycle, then again while stale responses remain.
    do_reset(3);
    repeat (3) cycle(0, 0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        cycle(1, 0, 32'h600, 1);
        cycle(0, 1, 32'h0, 1);
        found = 1'b1;
      end else begin
        cycle(0, 0, 0, 1);
      end
    end
    check("lit_resp_redirect", {31'b0, found}, 32'd1);
    run_until_valid(15, fpc, ok);
    check("lit_drop_found", {31'b0, ok}, 32'd1);
    check("lit_drop_pc",    fpc, EXC);
    repeat (6) cycle(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end: owns the PC, issues pipelined read requests to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO toward decode. Replaces the single-register IF stage with a decoupled, stall-tolerant queue that handles branch and exception redirects. It sits between the instruction ROM/cache port and the ID stage.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- MAX_OUTST, 2: maximum in-flight memory requests, 1..DEPTH
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- br  in  1  branch redirect to pc_branch
- pc_branch  in  32  branch target
- except  in  1  exception redirect to EXC_VECTOR (32'h8000_0180)
- imem_req  out  1  read request this cycle
- imem_addr  out  32  word-aligned request address
- imem_rvalid  in  1  response valid; responses in request order, latency ≥1 cycle
- imem_rdata  in  32  response instruction
- if_valid  out  1  queue head valid
- if_pc  out  32  PC of head instruction
- if_inst  out  32  head instruction
- id_ready  in  1  decode accepts head when if_valid && id_ready
- fetch_cnt  out  32  instructions delivered (see Configuration)
- flush_cnt  out  32  redirects taken (see Configuration)

## Operation
- State: fetch_pc, FIFO (pc, inst) with count, outst (in-flight requests), drop (stale responses still to discard).
- Issue: imem_req = !redirect && outst < MAX_OUTST && count + outst < DEPTH; imem_addr = fetch_pc. On issue fetch_pc += 4 (mod 2^32, wraps silently); the PC of each request is queued in a MAX_OUTST-deep tag FIFO.
- Response: on imem_rvalid, outst decrements; if drop > 0 the response is discarded and drop decrements, else {tag pc, imem_rdata} is pushed. Overflow is impossible by the slot-reservation rule; an imem_rvalid with outst == 0 is a protocol error (assertion).
- Pop: if_valid && id_ready removes the head. Push and pop in the same cycle are both performed; count is unchanged.
- Redirect (redirect = br || except; except has priority): FIFO emptied, tag FIFO cleared, fetch_pc ← EXC_VECTOR or pc_branch, drop ← outst minus any response arriving this cycle (that response is also discarded), no issue and no push this cycle. A pop in the redirect cycle still completes if id_ready is high.
- Redirect during drop > 0: drop is recomputed as above, so it accumulates all stale responses.

## Timing
- Reset values: imem_req 0 during reset, fetch_pc RESET_PC, count/outst/drop 0, if_valid 0, if_pc 0, if_inst 0, counters 0.
- First imem_req in the first cycle after rst deasserts.
- Load-to-use: response in cycle N → if_valid in cycle N+1 (registered FIFO, no bypass).
- With 1-cycle memory and MAX_OUTST ≥2, sustained throughput is 1 instruction/cycle while id_ready is high.
- Redirect in cycle R → first request to the target in R+1; with 1-cycle memory, target instruction is valid in R+3.
- rst mid-operation clears all state immediately; in-flight responses after reset release are undefined, so memory must also be reset.

## Configuration
- FETCH_PERF_EN defined: fetch_cnt increments on each pop, flush_cnt on each redirect cycle; both wrap at 2^32 and reset to 0.
- Undefined: both outputs tied to 0, no counter flops.

## Structure
- fetch_pkg: EXC_VECTOR constant, fetch_entry_t {pc, inst} struct, and a function computing the count width as $clog2(DEPTH+1).
- Sub-module fetch_fifo (parametrised depth, entry type, synchronous flush) used for both the instruction queue and the tag queue.

## Test plan
- Reset, 1-cycle memory returning addr+0x100, id_ready=1 → requests 0x0,0x4,0x8…; if_pc 0x0 valid in cycle 2 after reset release, then one instruction per cycle.
- id_ready=0 with DEPTH=4 → exactly 4 entries fill, imem_req drops to 0; raise id_ready → pops in order 0x0..0xC, no loss or duplication.
- br with pc_branch=0x400 while 2 requests in flight → both stale responses discarded, queue empty next cycle, next imem_addr 0x400, next if_pc 0x400.
- br and except asserted together with pc_branch=0x400 → next imem_addr 0x8000_0180.
- Response arriving in the redirect cycle plus a 3-cycle-latency memory → no stale instruction ever reaches if_valid.
- fetch_pc=0xFFFF_FFFC → next request address 0x0000_0000; with FETCH_PERF_EN, fetch_cnt equals the number of accepted pops and flush_cnt equals the number of redirect cycles.
